// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : RV32 execute stage with operand forwarding, ALU, beq/jal
//               redirect resolution and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ALUSrcE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [2:0]        ALUControlE,
    input  logic [1:0]        ResultSrcE,
    input  logic [XLEN-1:0]   RD1E,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   ImmExtE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic [31:0]       TakenCount
);

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b111;

    localparam logic [1:0] c_FWD_W = 2'b01;
    localparam logic [1:0] c_FWD_M = 2'b10;

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_write_data_e;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_result_e;
    logic              w_zero_e;

    logic              r_reg_write_m;
    logic              r_mem_write_m;
    logic [1:0]        r_result_src_m;
    logic [XLEN-1:0]   r_alu_result_m;
    logic [XLEN-1:0]   r_write_data_m;
    logic [XLEN-1:0]   r_pc_plus4_m;
    logic [REG_AW-1:0] r_rd_m;
    logic [31:0]       r_taken_count;

    // The M-stage forward source is this stage's own registered result.
    always_comb begin
        w_src_a = RD1E;
        case (ForwardAE)
            c_FWD_W: w_src_a = ResultW;
            c_FWD_M: w_src_a = r_alu_result_m;
            default: w_src_a = RD1E;
        endcase
    end

    always_comb begin
        w_write_data_e = RD2E;
        case (ForwardBE)
            c_FWD_W: w_write_data_e = ResultW;
            c_FWD_M: w_write_data_e = r_alu_result_m;
            default: w_write_data_e = RD2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? ImmExtE : w_write_data_e;

    always_comb begin
        w_alu_result_e = '0;
        case (ALUControlE)
            c_ALU_ADD:  w_alu_result_e = w_src_a + w_src_b;
            c_ALU_SUB:  w_alu_result_e = w_src_a - w_src_b;
            c_ALU_AND:  w_alu_result_e = w_src_a & w_src_b;
            c_ALU_OR:   w_alu_result_e = w_src_a | w_src_b;
            c_ALU_XOR:  w_alu_result_e = w_src_a ^ w_src_b;
            c_ALU_SLT:  w_alu_result_e = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            c_ALU_SLTU: w_alu_result_e = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            default:    w_alu_result_e = '0;
        endcase
    end

    assign w_zero_e  = (w_alu_result_e == '0);
    assign PCSrcE    = (BranchE & w_zero_e) | JumpE;
    assign PCTargetE = PCE + ImmExtE;

    // Flush takes priority over stall so a bubble can be injected into a held slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_pc_plus4_m   <= '0;
            r_rd_m         <= '0;
        end else if (FlushM) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_pc_plus4_m   <= '0;
            r_rd_m         <= '0;
        end else if (!StallM) begin
            r_reg_write_m  <= RegWriteE;
            r_mem_write_m  <= MemWriteE;
            r_result_src_m <= ResultSrcE;
            r_alu_result_m <= w_alu_result_e;
            r_write_data_m <= w_write_data_e;
            r_pc_plus4_m   <= PCPlus4E;
            r_rd_m         <= RdE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_taken_count <= 32'd0;
        end else if (PCSrcE && !StallM) begin
            r_taken_count <= r_taken_count + 32'd1;
        end
    end

    assign RegWriteM  = r_reg_write_m;
    assign MemWriteM  = r_mem_write_m;
    assign ResultSrcM = r_result_src_m;
    assign ALUResultM = r_alu_result_m;
    assign WriteDataM = r_write_data_m;
    assign PCPlus4M   = r_pc_plus4_m;
    assign RdM        = r_rd_m;
    assign TakenCount = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic        StallM, FlushM;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [31:0] TakenCount;

    int errors = 0;
    int checks = 0;

    // Reference state of the M stage
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [31:0] m_alu, m_wd, m_pc4, m_cnt;
    logic [4:0]  m_rd;

    ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE),
        .ResultSrcE(ResultSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .TakenCount(TakenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd,
                                         input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rd;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd7: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_cnt = 0;
    endtask

    task automatic check_m(input string tag);
        check({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, m_rw});
        check({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, m_mw});
        check({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, m_rs});
        check({tag, ".ALUResultM"}, ALUResultM, m_alu);
        check({tag, ".WriteDataM"}, WriteDataM, m_wd);
        check({tag, ".PCPlus4M"},   PCPlus4M, m_pc4);
        check({tag, ".RdM"},        {27'd0, RdM}, {27'd0, m_rd});
        check({tag, ".TakenCount"}, TakenCount, m_cnt);
    endtask

    // Check combinational outputs, then clock once and check the M stage.
    task automatic cycle(input string tag);
        logic [31:0] a, wd, b, res, tgt;
        logic        taken;
        #1;
        a     = pick(ForwardAE, RD1E, ResultW, m_alu);
        wd    = pick(ForwardBE, RD2E, ResultW, m_alu);
        b     = ALUSrcE ? ImmExtE : wd;
        res   = alu(ALUControlE, a, b);
        taken = JumpE || (BranchE && res == 32'd0);
        tgt   = PCE + ImmExtE;
        check({tag, ".PCSrcE"},    {31'd0, PCSrcE}, {31'd0, taken});
        check({tag, ".PCTargetE"}, PCTargetE, tgt);
        @(posedge clk);
        if (taken && !StallM) m_cnt = m_cnt + 1;
        if (FlushM) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        end else if (!StallM) begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
            m_alu = res; m_wd = wd; m_pc4 = PCPlus4E; m_rd = RdE;
        end
        #1;
        check_m(tag);
    endtask

    task automatic quiet_inputs();
        StallM = 0; FlushM = 0; RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0;
        BranchE = 0; JumpE = 0; ALUControlE = 0; ResultSrcE = 0;
        RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic rand_inputs();
        RegWriteE   = 1'($urandom);
        MemWriteE   = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        BranchE     = 1'($urandom);
        JumpE       = ($urandom_range(0, 7) == 0);
        ALUControlE = 3'($urandom);
        ResultSrcE  = 2'($urandom);
        RD1E        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        RD2E        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        ImmExtE     = $urandom;
        PCE         = $urandom;
        PCPlus4E    = $urandom;
        RdE         = 5'($urandom);
        ForwardAE   = 2'($urandom);
        ForwardBE   = 2'($urandom);
        ResultW     = $urandom;
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        check_m("reset");
        reset = 1'b0;

        // Seed ALUResultM with 100 for the forwarding checks.
        RD1E = 32'd100; RegWriteE = 1; RdE = 5'd3; PCPlus4E = 32'h44;
        cycle("seed");
        RD1E = 32'd5; RD2E = 32'd9; ForwardAE = 2'b10;
        cycle("fwdA");
        check("fwdA.alu109", ALUResultM, 32'd109);
        check("fwdA.wd9",    WriteDataM, 32'd9);
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'd7;
        cycle("fwdB");
        check("fwdB.wd7", WriteDataM, 32'd7);

        // Branch taken, then not taken
        quiet_inputs();
        BranchE = 1; ALUControlE = 3'b001; RD1E = 32'h20; RD2E = 32'h20;
        PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
        #1;
        check("beq.pcsrc",  {31'd0, PCSrcE}, 32'd1);
        check("beq.target", PCTargetE, 32'hF8);
        cycle("beq");
        check("beq.count", TakenCount, 32'd1);
        RD2E = 32'h21;
        #1;
        check("bne.pcsrc", {31'd0, PCSrcE}, 32'd0);
        cycle("bne");

        // slt vs sltu, and add wrap
        quiet_inputs();
        RD1E = 32'hFFFFFFFF; RD2E = 32'd1; ALUControlE = 3'b101;
        cycle("slt");
        check("slt.one", ALUResultM, 32'd1);
        ALUControlE = 3'b111;
        cycle("sltu");
        check("sltu.zero", ALUResultM, 32'd0);
        ALUControlE = 3'b000; RD2E = 32'd1;
        cycle("addwrap");
        check("addwrap.zero", ALUResultM, 32'd0);

        // Load distinctive state, then stall three cycles while inputs change
        quiet_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RD1E = 32'hABCD; RD2E = 32'h1234;
        RdE = 5'd17; PCPlus4E = 32'h200;
        cycle("load");
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            JumpE = 1;
            StallM = 1; FlushM = 0;
            cycle("stall");
        end
        check("stall.rd17", {27'd0, RdM}, 32'd17);
        StallM = 1; FlushM = 1; JumpE = 0;
        cycle("stallflush");
        check("stallflush.rw", {31'd0, RegWriteM}, 32'd0);
        check("stallflush.rd", {27'd0, RdM}, 32'd0);

        // Async reset between edges with live state
        quiet_inputs();
        RegWriteE = 1; RD1E = 32'h55; RdE = 5'd9; JumpE = 1;
        cycle("preReset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_m("asyncReset");
        #1;
        reset = 1'b0;
        JumpE = 0;
        cycle("postReset");

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            StallM = ($urandom_range(0, 5) == 0);
            FlushM = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage RV32 pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its E-stage outputs. It applies forwarding selected by the hazard unit, computes the ALU result, and resolves beq/jal redirection combinationally. The control and data for the memory stage are captured in an internal EX/MEM register.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-index width

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
StallM  input  1  hold the EX/MEM register contents
FlushM  input  1  load a bubble into EX/MEM
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  input  1 each  control from ID/EX
ALUControlE  input  3  ALU operation
ResultSrcE  input  2  writeback select, passed through
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  input  XLEN each  operands and PC values from ID/EX
RdE  input  REG_AW  destination register
ForwardAE, ForwardBE  input  2 each  forwarding selects from the hazard unit
ALUResultM_fwd  input  XLEN  not a port; forwarding uses the internal ALUResultM
ResultW  input  XLEN  writeback result
PCSrcE  output  1  redirect taken (combinational)
PCTargetE  output  XLEN  redirect target (combinational)
RegWriteM, MemWriteM  output  1 each  registered
ResultSrcM  output  2  registered
ALUResultM, WriteDataM, PCPlus4M  output  XLEN each  registered
RdM  output  REG_AW  registered
TakenCount  output  32  count of taken redirects (debug)

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset is asynchronous and active-high, on port reset.
- Forwarding mux A: ForwardAE 00 selects RD1E, 01 selects ResultW, 10 selects ALUResultM, 11 selects RD1E. Result is SrcAE.
- Forwarding mux B: same encoding with RD2E. Result is WriteDataE.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations by ALUControlE:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt (signed) and 111 sltu (unsigned), each giving 1 or 0 zero-extended.
  - 110 gives 0.
  - add and sub wrap modulo 2^XLEN.
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE. It is purely combinational, with zero latency.
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN. It is driven every cycle regardless of PCSrcE.
- EX/MEM register, updated on the rising clk edge:
  - reset asserted: all registered outputs are 0 immediately, without waiting for a clock edge. TakenCount is 0.
  - else if FlushM: RegWriteM = 0, MemWriteM = 0, ResultSrcM = 00, RdM = 0, and data outputs = 0. This is a bubble.
  - else if StallM: all registered outputs hold.
  - else: RegWriteM, MemWriteM, ResultSrcM, RdM and PCPlus4M load their E-stage values. ALUResultM loads ALUResultE; WriteDataM loads WriteDataE (the forwarded value, not raw RD2E).
  - FlushM together with StallM: flush wins.
- TakenCount:
  - Increments by 1 on each clock edge where PCSrcE = 1 and StallM = 0.
  - Wraps from 0xFFFFFFFF to 0.
  - Unaffected by FlushM.
- The ALUResultM fed back to forwarding mux A/B is the current registered value, i.e. the instruction one stage ahead.
- Reset mid-stall: reset dominates, and outputs go to 0 immediately.
- After reset deasserts, the first rising edge loads normally.
- No internal FSM beyond the register. Stage latency is 1 cycle from E inputs to M outputs.

Test Plan:
1. Async reset: pulse reset between clock edges with nonzero state loaded → all M outputs and TakenCount read 0 before the next edge.
2. Add with forwarding:
   - RD1E=5, RD2E=9, ForwardAE=10 with ALUResultM=100, ALUControlE=000, ALUSrcE=0 → next edge ALUResultM=109, WriteDataM=9.
   - ForwardBE=01 with ResultW=7 → WriteDataM=7.
3. Branch resolution:
   - BranchE=1, ALUControlE=001, RD1E=RD2E=0x20, PCE=0x100, ImmExtE=0xFFFFFFF8 → PCSrcE=1 and PCTargetE=0xF8 in the same cycle; TakenCount increments.
   - RD2E=0x21 → PCSrcE=0.
4. slt vs sltu: SrcA=0xFFFFFFFF, SrcB=1 → ALUControlE=101 gives ALUResultM=1; 111 gives 0.
5. Stall and flush:
   - StallM=1 for 3 cycles while E inputs change → M outputs hold.
   - StallM=1 with FlushM=1 → RegWriteM=0, MemWriteM=0, RdM=0.
   - JumpE=1 while StallM=1 → TakenCount unchanged.
6. Wrap:
   - Preset TakenCount near max via 2^32−1 taken cycles, or use a forced start value → the next taken edge gives TakenCount=0.
   - SrcA=0xFFFFFFFF plus SrcB=1 with add → ALUResultM=0.
